// File: rtl/gcounter_ctrl_if.sv
// Control and counter-side signal bundle for gcounter_ctrl.
// master drives requests and the counter's Gray value; slave is the controller.
interface gcounter_ctrl_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned PW = 8
);
  logic          start_i;
  logic          stop_i;
  logic [1:0]    mode_i;
  logic [W-1:0]  target_i;
  logic [PW-1:0] div_i;
  logic [W-1:0]  gray_i;
  logic          cnt_rst_n_o;
  logic          cnt_en_o;
  logic          busy_o;
  logic          done_o;
  logic          hit_o;
  logic [7:0]    hit_cnt_o;
  logic [W-1:0]  bin_o;

  modport master (
    output start_i, stop_i, mode_i, target_i, div_i, gray_i,
    input  cnt_rst_n_o, cnt_en_o, busy_o, done_o, hit_o, hit_cnt_o, bin_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, target_i, div_i, gray_i,
    output cnt_rst_n_o, cnt_en_o, busy_o, done_o, hit_o, hit_cnt_o, bin_o
  );
endinterface

// File: rtl/gcounter_ctrl.sv
// Run controller for a W-bit Gray counter: clear, prescaled enable pulses,
// Gray-to-binary decode and terminal-count detection in three run modes.
module gcounter_ctrl #(
  parameter int unsigned W  = 4,
  parameter int unsigned PW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  gcounter_ctrl_if.slave bus
);

  localparam int unsigned HW     = 8;
  localparam logic [1:0]  M_CONT = 2'b01;
  localparam logic [1:0]  M_STEP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PULSE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  target_q, target_d;
  logic [PW-1:0] div_q, div_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_rst_n_q, cnt_rst_n_d;
  logic          cnt_en_q, cnt_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [W-1:0]  dec;
  logic          match;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign dec   = gray2bin(bus.gray_i);
  assign match = (dec == target_q);

  // State register and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      target_q    <= '0;
      div_q       <= '0;
      presc_q     <= '0;
      cnt_rst_n_q <= 1'b0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_cnt_q   <= '0;
      bin_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      cnt_en_q    <= cnt_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_cnt_q   <= hit_cnt_d;
      bin_q       <= bin_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    div_d     = div_q;
    presc_d   = presc_q;
    hit_d     = 1'b0;
    hit_cnt_d = hit_cnt_q;
    bin_d     = bin_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          mode_d   = bus.mode_i;
          target_d = bus.target_i;
          div_d    = bus.div_i;
          if (bus.mode_i == M_STEP) begin
            state_d = S_RUN;
            presc_d = bus.div_i;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        state_d   = S_CHECK;
        hit_cnt_d = '0;
      end
      S_RUN: begin
        if (presc_q == '0) begin
          state_d = S_PULSE;
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
      S_PULSE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        bin_d = dec;
        if (mode_q == M_STEP) begin
          state_d = S_DONE;
        end else if (mode_q == M_CONT) begin
          state_d = S_RUN;
          presc_d = div_q;
          if (match) begin
            hit_d = 1'b1;
            if (hit_cnt_q != {HW{1'b1}}) begin
              hit_cnt_d = hit_cnt_q + HW'(1);
            end
          end
        end else if (match) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          presc_d = div_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every transition; the counter is left untouched
    if (state_q != S_IDLE && bus.stop_i) begin
      state_d   = S_IDLE;
      hit_d     = 1'b0;
      hit_cnt_d = hit_cnt_q;
    end

    busy_d      = (state_d != S_IDLE);
    cnt_en_d    = (state_d == S_PULSE);
    cnt_rst_n_d = (state_d != S_CLEAR);
    done_d      = (state_d == S_DONE);
  end

  assign bus.cnt_rst_n_o = cnt_rst_n_q;
  assign bus.cnt_en_o    = cnt_en_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.hit_o       = hit_q;
  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.bin_o       = bin_q;

endmodule

// File: tb/tb_gcounter_ctrl.sv
// Scoreboard bench for gcounter_ctrl with a behavioural 4-bit Gray counter
// driven by the controller's reset and enable outputs.
module tb_gcounter_ctrl;

  typedef struct {
    int kind;   // 0 = done_o, 1 = hit_o
    int cyc;    // cycle index after the start edge
    int bin;
    int hc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_bin;
  int         cyc = 0;
  int         start_cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         en_cnt = 0;
  int         last_en = 0;
  int         last_valid = 0;
  int         exp_period = 0;
  ev_t        exp_q[$];

  gcounter_ctrl_if #(.W(4), .PW(8)) cif ();

  gcounter_ctrl #(.W(4), .PW(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (cif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter under control: async active-low clear, counts when enable sampled high
  always @(posedge clk or negedge cif.cnt_rst_n_o) begin
    if (!cif.cnt_rst_n_o) cnt_bin <= 4'd0;
    else if (cif.cnt_en_o) cnt_bin <= cnt_bin + 4'd1;
  end
  assign cif.gray_i = cnt_bin ^ (cnt_bin >> 1);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic exp_ev(input int k, input int c, input int b, input int h);
    ev_t e;
    e.kind = k; e.cyc = c; e.bin = b; e.hc = h;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [3:0] t, input logic [7:0] d);
    @(negedge clk);
    cif.mode_i   = m;
    cif.target_i = t;
    cif.div_i    = d;
    cif.start_i  = 1'b1;
    start_cyc    = cyc + 1;
    last_valid   = 0;
    en_cnt       = 0;
    @(negedge clk);
    cif.start_i  = 1'b0;
    cif.target_i = ~t;
    cif.div_i    = ~d;
    cif.mode_i   = ~m;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cif.busy_o) break;
    end
    if (i == budget) chk("idle_timeout", int'(cif.busy_o), 0);
  endtask

  // Monitor: pops the scoreboard on every done_o / hit_o, tracks enable spacing
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cif.cnt_en_o) begin
          if (last_valid != 0) chk("en_period", cyc - last_en, exp_period);
          last_en    = cyc;
          last_valid = 1;
          en_cnt++;
        end
        if (cif.done_o || cif.hit_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", int'(cif.hit_o) * 2 + int'(cif.done_o), 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", int'(cif.hit_o), e.kind);
            chk("event_cycle", cyc - start_cyc + 1, e.cyc);
            chk("event_bin", int'(cif.bin_o), e.bin);
            chk("event_hit_cnt", int'(cif.hit_cnt_o), e.hc);
          end
        end
      end
    end
  end

  initial begin
    int pc;
    cif.start_i  = 1'b0;
    cif.stop_i   = 1'b0;
    cif.mode_i   = 2'b00;
    cif.target_i = 4'd0;
    cif.div_i    = 8'd0;

    // Power-on reset
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt_rst_n", int'(cif.cnt_rst_n_o), 0);
    chk("rst_busy", int'(cif.busy_o), 0);
    chk("rst_done", int'(cif.done_o), 0);
    chk("rst_hit", int'(cif.hit_o), 0);
    chk("rst_hit_cnt", int'(cif.hit_cnt_o), 0);
    chk("rst_bin", int'(cif.bin_o), 0);
    chk("rst_cnt_en", int'(cif.cnt_en_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cnt_rst_n", int'(cif.cnt_rst_n_o), 1);

    // One-shot, div 0, target 5: 2 + 5*3 + 1 = 18
    exp_period = 3;
    exp_ev(0, 18, 5, 0);
    start_run(2'b00, 4'd5, 8'd0);
    wait_idle(60);
    chk("os5_pulses", en_cnt, 5);
    chk("os5_bin", int'(cif.bin_o), 5);
    chk("os5_pending", exp_q.size(), 0);

    // One-shot (mode 11) with target 0: done at cycle 3, no pulses
    exp_ev(0, 3, 0, 0);
    start_run(2'b11, 4'd0, 8'd4);
    wait_idle(20);
    chk("os0_pulses", en_cnt, 0);
    chk("os0_pending", exp_q.size(), 0);

    // Continuous, div 1, target 3: hits at steps 3, 19, 35 (cycle 3 + 4*k)
    exp_period = 4;
    exp_ev(1, 15, 3, 1);
    exp_ev(1, 79, 3, 2);
    exp_ev(1, 143, 3, 3);
    start_run(2'b01, 4'd3, 8'd1);
    repeat (162) @(negedge clk);
    cif.stop_i = 1'b1;
    @(negedge clk);
    cif.stop_i = 1'b0;
    chk("cont_stop_busy", int'(cif.busy_o), 0);
    chk("cont_hit_cnt", int'(cif.hit_cnt_o), 3);
    chk("cont_pulses", en_cnt, 40);
    chk("cont_pending", exp_q.size(), 0);

    // Park the counter at 15, then single-step across the wrap
    exp_period = 3;
    exp_ev(0, 48, 15, 0);
    start_run(2'b00, 4'd15, 8'd0);
    wait_idle(100);
    chk("park15_cnt", int'(cnt_bin), 15);
    exp_ev(0, 6, 0, 0);
    start_run(2'b10, 4'd9, 8'd2);
    wait_idle(20);
    chk("step1_pulses", en_cnt, 1);
    chk("step1_gray", int'(cif.gray_i), 0);
    exp_ev(0, 4, 1, 0);
    start_run(2'b10, 4'd9, 8'd0);
    wait_idle(20);
    chk("step2_bin", int'(cif.bin_o), 1);
    chk("step_pending", exp_q.size(), 0);

    // Start while busy is ignored: target stays 2, period stays 6
    exp_period = 6;
    exp_ev(0, 15, 2, 0);
    start_run(2'b00, 4'd2, 8'd3);
    @(negedge clk);
    cif.start_i  = 1'b1;
    cif.mode_i   = 2'b01;
    cif.target_i = 4'd9;
    cif.div_i    = 8'd0;
    @(negedge clk);
    cif.start_i  = 1'b0;
    wait_idle(40);
    chk("busy_start_pulses", en_cnt, 2);
    chk("busy_start_pending", exp_q.size(), 0);

    // Start and stop together in IDLE
    @(negedge clk);
    cif.start_i = 1'b1;
    cif.stop_i  = 1'b1;
    @(negedge clk);
    cif.start_i = 1'b0;
    cif.stop_i  = 1'b0;
    chk("startstop_busy", int'(cif.busy_o), 0);
    @(negedge clk);
    chk("startstop_busy2", int'(cif.busy_o), 0);

    // Stop during PULSE: the enable still lands, no clear, no done
    exp_period = 3;
    start_run(2'b00, 4'd7, 8'd0);
    pc = 0;
    for (int i = 0; i < 20 && pc < 2; i++) begin
      @(negedge clk);
      if (cif.cnt_en_o) pc++;
    end
    if (pc == 2) begin
      cif.stop_i = 1'b1;
      @(negedge clk);
      cif.stop_i = 1'b0;
      chk("pstop_busy", int'(cif.busy_o), 0);
      chk("pstop_cnt", int'(cnt_bin), 2);
      repeat (3) @(negedge clk);
      chk("pstop_cnt_hold", int'(cnt_bin), 2);
      chk("pstop_cnt_rst_n", int'(cif.cnt_rst_n_o), 1);
    end else begin
      chk("pstop_pulse_seen", pc, 2);
    end
    chk("pstop_pending", exp_q.size(), 0);

    // Asynchronous reset mid-run
    exp_period = 5;
    start_run(2'b00, 4'd10, 8'd2);
    repeat (12) @(negedge clk);
    chk("pre_rst_bin", int'(cif.bin_o), 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(cif.busy_o), 0);
    chk("mid_rst_cnt_rst_n", int'(cif.cnt_rst_n_o), 0);
    chk("mid_rst_cnt_en", int'(cif.cnt_en_o), 0);
    chk("mid_rst_bin", int'(cif.bin_o), 0);
    chk("mid_rst_counter", int'(cnt_bin), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_cnt_rst_n", int'(cif.cnt_rst_n_o), 1);
    chk("mid_rel_busy", int'(cif.busy_o), 0);
    chk("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gcounter_ctrl.md
# gcounter_ctrl

Run controller for the 4-bit Gray-code counter. It clears the counter, issues prescaled single-cycle enable pulses, decodes the counter's Gray output back to binary, and stops at a programmed terminal count. It supports three modes: one-shot, continuous with a hit counter, and single-step. It sits between the control/switch logic and the counter, and drives the counter's active-low reset and enable pins.

## Interface
Parameters:
- W, 4, counter width (gray_i, target_i, bin_o)
- PW, 8, prescaler width (div_i)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request; sampled only in IDLE
- stop_i  in  1  abort; sampled in every non-IDLE state
- mode_i  in  2  00 one-shot, 01 continuous, 10 single-step, 11 treated as one-shot; latched on start
- target_i  in  W  binary terminal count; latched on start
- div_i  in  PW  prescale value; latched on start
- gray_i  in  W  counter's registered Gray output
- cnt_rst_n_o  out  1  counter reset, active low
- cnt_en_o  out  1  counter enable, one cycle per step
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse (one-shot, step)
- hit_o  out  1  one-cycle pulse on each target match (continuous)
- hit_cnt_o  out  8  saturating match count, cleared on start
- bin_o  out  W  binary decode of gray_i, registered in CHECK

## Operation
- Counter contract: the counter samples cnt_en_o at a rising edge. Its gray_i shows the new value in the cycle immediately after the cnt_en_o-high cycle. A low cnt_rst_n_o clears it asynchronously to 0.
- Gray-to-binary decode: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i].
- All outputs are decoded from registered state or registered directly. There are no combinational input-to-output paths.

States:
- IDLE: busy_o 0, cnt_rst_n_o 1, cnt_en_o 0.
  - start_i=1 and stop_i=0: latch mode, target and div.
  - Step mode goes to RUN. All other modes go to CLEAR.
- CLEAR (1 cycle): cnt_rst_n_o 0. Also clears hit_cnt_o. Next state is CHECK.
- RUN: a prescaler loads div on entry and decrements each cycle. When it reads 0, go to PULSE. RUN therefore lasts div+1 cycles.
- PULSE (1 cycle): cnt_en_o 1. Next state is CHECK.
- CHECK (1 cycle): bin_o <= decode(gray_i); match = (decoded value == target).
  - One-shot: match goes to DONE, otherwise RUN.
  - Step: always goes to DONE.
  - Continuous: on match, hit_o pulses in the next cycle and hit_cnt_o increments, saturating at 255. Always returns to RUN.
- DONE (1 cycle): done_o 1. Next state is IDLE.

Boundary rules:
- stop_i in any non-IDLE state goes to IDLE next edge.
  - No done_o is issued.
  - The counter keeps its value; there is no clear.
  - stop_i has priority over every other transition, including PULSE->CHECK. An enable already driven in PULSE still takes effect.
- start_i while busy is ignored.
- start_i and stop_i together in IDLE: stay in IDLE.
- target_i = 0 in one-shot: CLEAR -> CHECK matches immediately. done_o follows with zero enable pulses.
- The counter wraps from max to 0 naturally. One-shot always terminates within 2^W steps.
- Continuous mode runs until stop_i.
- Input changes after start have no effect until the next start.

## Timing
- Reset values: IDLE, cnt_rst_n_o 0 while rst_i is high, cnt_en_o 0, busy_o 0, done_o 0, hit_o 0, hit_cnt_o 0, bin_o 0. cnt_rst_n_o returns to 1 on the first edge after reset release.
- Reset mid-operation returns everything to reset values immediately and clears the counter.
- Start latency:
  - start_i sampled at edge 0 gives busy_o = 1 after edge 0.
  - CLEAR occupies cycle 1.
  - CHECK on value 0 occupies cycle 2.
- Step period: RUN (div+1) + PULSE (1) + CHECK (1) = div+3 cycles between cnt_en_o pulses.
- One-shot total from start edge to the done_o cycle, with target T>0: 2 + T*(div+3) + 1 cycles.

## Test plan
- Reset: assert rst_i mid-RUN → all outputs return to reset values asynchronously, cnt_rst_n_o is 0 while rst_i is high, state is IDLE after release.
- One-shot with div=0, target=5:
  - Exactly 5 cnt_en_o pulses, 3 cycles apart.
  - gray_i sequence is 0,1,3,2,6,7.
  - bin_o ends at 5.
  - done_o is high for 1 cycle at cycle 18 after the start edge.
- One-shot with target=0: done_o at cycle 3, no cnt_en_o pulses.
- Continuous with div=1, target=3, run 40 steps:
  - hit_o pulses on step 3 and after each wrap (steps 3, 19, 35).
  - hit_cnt_o = 3.
  - stop_i returns busy_o to 0 next cycle with no done_o.
- Step mode with counter holding 15 (binary):
  - One cnt_en_o pulse; gray_i = 0, bin_o = 0 (wrap).
  - done_o pulse follows.
  - A second step shows bin_o = 1.
- Contention:
  - start_i while busy is ignored; latched target is unchanged.
  - start_i and stop_i together in IDLE leave busy_o at 0.
  - stop_i during PULSE: the counter still advances by 1, and the controller returns to IDLE.
